// File: rtl/dma_chan_sched.sv
// rtl/dma_chan_sched.sv - four-channel round-robin DMA word scheduler feeding a host ring buffer
// Optional WAIT watchdog with sticky err_o is enabled by defining DMA_TIMEOUT_EN.
module dma_chan_sched #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable_i,
    input  logic         cfg_bus_mstr_enable,
    input  logic [3:0]   req_i,
    input  logic [127:0] ch_data_i,
    input  logic [29:0]  buf_base_i,
    input  logic [15:0]  buf_size_i,
    input  logic         dma_rd_en,
    output logic         dma_start,
    output logic [29:0]  dma_addr,
    output logic [31:0]  dma_data,
    output logic [3:0]   ack_o,
    output logic         start_int_o,
    output logic         busy_o,
    output logic [15:0]  wptr_o,
    output logic         err_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [15:0] wptr_q, wptr_d;
    logic        dma_start_q, dma_start_d;
    logic [29:0] dma_addr_q, dma_addr_d;
    logic [31:0] dma_data_q, dma_data_d;
    logic [3:0]  ack_q, ack_d;
    logic        start_int_q, start_int_d;

    logic        rr_found;
    logic [1:0]  rr_pick;
    logic [1:0]  rr_idx;
    logic [15:0] wptr_last;

`ifdef DMA_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // Search order starts just after the last granted channel; the 4th probe revisits it.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_grant_q;
        rr_idx   = last_grant_q;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_grant_q + 2'(i);
            if (!rr_found && req_i[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // A size of 0 encodes a full 64K-DW buffer.
    assign wptr_last = (buf_size_i == 16'd0) ? 16'hFFFF : buf_size_i - 16'd1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wptr_d       = wptr_q;
        dma_start_d  = 1'b0;
        dma_addr_d   = dma_addr_q;
        dma_data_d   = dma_data_q;
        ack_d        = 4'd0;
        start_int_d  = 1'b0;
`ifdef DMA_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!enable_i) begin
                    wptr_d       = 16'd0;
                    last_grant_d = 2'd3;
`ifdef DMA_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                end else if (cfg_bus_mstr_enable && rr_found) begin
                    last_grant_d = rr_pick;
                    state_d      = ST_START;
                    dma_start_d  = 1'b1;
                    dma_addr_d   = buf_base_i + {14'd0, wptr_q};
                    dma_data_d   = ch_data_i[{rr_pick, 5'd0} +: 32];
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef DMA_TIMEOUT_EN
                tmo_cnt_d = 32'd0;
`endif
            end
            ST_WAIT: begin
                if (dma_rd_en) begin
                    state_d             = ST_IDLE;
                    ack_d[last_grant_q] = 1'b1;
                    if (wptr_q >= wptr_last) begin
                        wptr_d      = 16'd0;
                        start_int_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + 16'd1;
                    end
                end
`ifdef DMA_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd3;
            wptr_q       <= 16'd0;
            dma_start_q  <= 1'b0;
            dma_addr_q   <= 30'd0;
            dma_data_q   <= 32'd0;
            ack_q        <= 4'd0;
            start_int_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wptr_q       <= wptr_d;
            dma_start_q  <= dma_start_d;
            dma_addr_q   <= dma_addr_d;
            dma_data_q   <= dma_data_d;
            ack_q        <= ack_d;
            start_int_q  <= start_int_d;
        end
    end

`ifdef DMA_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign dma_start   = dma_start_q;
    assign dma_addr    = dma_addr_q;
    assign dma_data    = dma_data_q;
    assign ack_o       = ack_q;
    assign start_int_o = start_int_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign wptr_o      = wptr_q;

endmodule

// File: tb/tb_dma_chan_sched.sv
// tb/tb_dma_chan_sched.sv - self-checking bench for dma_chan_sched against a transaction-level model
module tb_dma_chan_sched;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable_i;
    logic         cfg_bus_mstr_enable;
    logic [3:0]   req_i;
    logic [127:0] ch_data_i;
    logic [29:0]  buf_base_i;
    logic [15:0]  buf_size_i;
    logic         dma_rd_en;
    logic         dma_start;
    logic [29:0]  dma_addr;
    logic [31:0]  dma_data;
    logic [3:0]   ack_o;
    logic         start_int_o;
    logic         busy_o;
    logic [15:0]  wptr_o;
    logic         err_o;

    dma_chan_sched #(.TIMEOUT_CYC(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_i            (enable_i),
        .cfg_bus_mstr_enable (cfg_bus_mstr_enable),
        .req_i               (req_i),
        .ch_data_i           (ch_data_i),
        .buf_base_i          (buf_base_i),
        .buf_size_i          (buf_size_i),
        .dma_rd_en           (dma_rd_en),
        .dma_start           (dma_start),
        .dma_addr            (dma_addr),
        .dma_data            (dma_data),
        .ack_o               (ack_o),
        .start_int_o         (start_int_o),
        .busy_o              (busy_o),
        .wptr_o              (wptr_o),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: ring pointer, last served channel, sticky error.
    int m_wptr = 0;
    int m_last = 3;
    int m_err  = 0;
    int irq_cnt = 0;

    logic [3:0]  oa;
    logic        oi;
    logic [29:0] oad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_expect(input logic [3:0] req, input int last);
        for (int i = 1; i <= 4; i++)
            if (req[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_idle_clear();
        m_wptr = 0;
        m_last = 3;
        m_err  = 0;
    endtask

    task automatic do_word(input logic [3:0] req, input int delay, input bit rd_in_start,
                           input int max_wait, input bit drop_en,
                           output logic [3:0] obs_ack, output logic obs_irq,
                           output logic [29:0] obs_addr);
        logic [127:0] d;
        int           exp_ch;
        logic [29:0]  exp_addr;
        logic [31:0]  exp_data;
        bit           seen;
        bit           exp_irq;
        int           size;
        obs_ack  = '0;
        obs_irq  = 1'b0;
        obs_addr = '0;
        d         = rand128();
        req_i     = req;
        ch_data_i = d;
        exp_ch    = rr_expect(req, m_last);
        exp_addr  = buf_base_i + 30'(m_wptr);
        exp_data  = d[exp_ch * 32 +: 32];
        seen = 1'b0;
        for (int k = 0; k < max_wait && !seen; k++) begin
            tick();
            seen = dma_start;
        end
        chk("dma_start_seen", seen, 1);
        if (!seen) return;
        m_last   = exp_ch;
        obs_addr = dma_addr;
        chk("busy_in_start", busy_o, 1);
        chk("ack_in_start", ack_o, 0);
        chk("dma_addr", dma_addr, exp_addr);
        chk("dma_data", dma_data, exp_data);
        for (int w = 0; w < delay; w++) begin
            dma_rd_en = (w == 0) && rd_in_start;
            if (w == 0 && drop_en) enable_i = 1'b0;
            req_i     = 4'($urandom());
            ch_data_i = rand128();
            tick();
            dma_rd_en = 1'b0;
            chk("start_one_cycle", dma_start, 0);
            chk("busy_in_wait", busy_o, 1);
            chk("ack_in_wait", ack_o, 0);
            chk("addr_hold", dma_addr, exp_addr);
            chk("data_hold", dma_data, exp_data);
        end
        size    = (buf_size_i == 16'd0) ? 65536 : int'(buf_size_i);
        exp_irq = (m_wptr + 1 >= size);
        m_wptr  = exp_irq ? 0 : m_wptr + 1;
        dma_rd_en = 1'b1;
        tick();
        dma_rd_en = 1'b0;
        req_i     = 4'd0;
        obs_ack   = ack_o;
        obs_irq   = start_int_o;
        irq_cnt  += int'(start_int_o);
        chk("ack_onehot", ack_o, 64'd1 << exp_ch);
        chk("start_int", start_int_o, exp_irq);
        chk("wptr", wptr_o, m_wptr);
        chk("busy_after_ack", busy_o, 0);
        chk("err_o", err_o, m_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0]  exp_ack_seq [5];
        logic [29:0] exp_off_seq [5];
        logic        exp_irq_seq [5];
        logic [3:0]  rq;
        bit          seen;
        int          dly;
        bit          rds;
        exp_ack_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_off_seq = '{30'd0, 30'd1, 30'd2, 30'd3, 30'd0};
        exp_irq_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; enable_i = 1'b0; cfg_bus_mstr_enable = 1'b0; req_i = 4'd0;
        ch_data_i = '0; buf_base_i = '0; buf_size_i = '0; dma_rd_en = 1'b0;
        tick(); tick();
        chk("rst_dma_start", dma_start, 0);
        chk("rst_dma_addr", dma_addr, 0);
        chk("rst_dma_data", dma_data, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_start_int", start_int_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wptr", wptr_o, 0);
        chk("rst_err", err_o, 0);
        rst_n = 1'b1;
        tick();

        // Round-robin from reset and ring addressing with size 4
        enable_i = 1'b1; cfg_bus_mstr_enable = 1'b1;
        buf_base_i = 30'h100; buf_size_i = 16'd4; irq_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            do_word(4'b1111, 2, 1'b0, 8, 1'b0, oa, oi, oad);
            chk("rr_seq_ack", oa, exp_ack_seq[n]);
            chk("ring_addr_seq", oad, 30'h100 + exp_off_seq[n]);
            chk("irq_seq", oi, exp_irq_seq[n]);
        end
        chk("irq_count_size4", irq_cnt, 1);

        // dma_rd_en during START must be ignored
        do_word(4'b0101, 2, 1'b1, 8, 1'b0, oa, oi, oad);

        // enable low in IDLE clears pointer and round-robin state
        enable_i = 1'b0;
        tick(); tick();
        model_idle_clear();
        chk("disable_wptr", wptr_o, 0);
        chk("disable_busy", busy_o, 0);
        enable_i = 1'b1;
        do_word(4'b0110, 1, 1'b0, 8, 1'b0, oa, oi, oad);
        chk("rr_after_disable", oa, 4'b0010);

        // Bus master gate
        cfg_bus_mstr_enable = 1'b0; req_i = 4'b0001;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("bme_no_start", dma_start, 0);
        end
        chk("bme_idle", busy_o, 0);
        cfg_bus_mstr_enable = 1'b1;
        do_word(4'b0001, 2, 1'b0, 2, 1'b0, oa, oi, oad);
        chk("bme_grant", oa, 4'b0001);

        // enable dropped mid-transfer completes, then idles
        do_word(4'b1111, 3, 1'b0, 8, 1'b1, oa, oi, oad);
        chk("drop_en_ack", oa, 4'b0010);
        model_idle_clear();
        req_i = 4'b1111;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("drop_en_no_start", dma_start, 0);
            chk("drop_en_busy", busy_o, 0);
        end
        chk("drop_en_wptr", wptr_o, 0);
        req_i = 4'd0; enable_i = 1'b1;

        // Shrinking the buffer below wptr wraps on the next completion
        buf_base_i = 30'h200; buf_size_i = 16'd16;
        for (int n = 0; n < 10; n++)
            do_word(4'($urandom_range(1, 15)), 1, 1'b0, 8, 1'b0, oa, oi, oad);
        chk("wptr_before_shrink", wptr_o, 10);
        buf_size_i = 16'd4;
        do_word(4'b1000, 1, 1'b0, 8, 1'b0, oa, oi, oad);
        chk("shrink_irq", oi, 1);
        chk("shrink_wptr", wptr_o, 0);

        // Size 0 means 64K DWs: no wrap over short runs
        buf_size_i = 16'd0; irq_cnt = 0;
        for (int n = 0; n < 20; n++)
            do_word(4'($urandom_range(1, 15)), 1, 1'b0, 8, 1'b0, oa, oi, oad);
        chk("size0_no_irq", irq_cnt, 0);
        chk("size0_wptr", wptr_o, 20);

        // 30-bit address arithmetic wraps modulo 2^30
        buf_base_i = 30'h3FFF_FFFE; buf_size_i = 16'd8;
        do_word(4'b0001, 1, 1'b0, 8, 1'b0, oa, oi, oad);
        chk("addr_mod_wrap", oad, 30'h12);
        chk("addr_mod_irq", oi, 1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            buf_base_i = 30'($urandom());
            buf_size_i = 16'($urandom_range(1, 8));
            rq  = 4'($urandom_range(1, 15));
            dly = $urandom_range(1, 4);
            rds = 1'($urandom_range(0, 1));
            do_word(rq, dly, rds, 8, 1'b0, oa, oi, oad);
            if (n % 15 == 14) begin
                enable_i = 1'b0;
                tick();
                model_idle_clear();
                chk("rand_disable_wptr", wptr_o, 0);
                enable_i = 1'b1;
            end
        end

`ifdef DMA_TIMEOUT_EN
        req_i = 4'b0010;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            seen = dma_start;
        end
        chk("tmo_start_seen", seen, 1);
        m_last = rr_expect(4'b0010, m_last);
        req_i = 4'd0;
        for (int w = 0; w < 16; w++) begin
            tick();
            chk("tmo_err_early", err_o, 0);
            chk("tmo_busy_early", busy_o, 1);
        end
        tick();
        chk("tmo_err_set", err_o, 1);
        chk("tmo_idle", busy_o, 0);
        chk("tmo_no_ack", ack_o, 0);
        chk("tmo_no_irq", start_int_o, 0);
        chk("tmo_wptr", wptr_o, m_wptr);
        m_err = 1;
        tick();
        chk("tmo_err_sticky", err_o, 1);
        enable_i = 1'b0;
        tick();
        chk("tmo_err_clear", err_o, 0);
        model_idle_clear();
        enable_i = 1'b1;
`else
        do_word(4'b0100, 40, 1'b0, 8, 1'b0, oa, oi, oad);
        chk("long_wait_no_err", err_o, 0);
`endif

        // Reset in the middle of WAIT drops the transfer
        buf_size_i = 16'd8;
        do_word(4'b0011, 1, 1'b0, 8, 1'b0, oa, oi, oad);
        req_i = 4'b0001;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            seen = dma_start;
        end
        chk("rstwait_start_seen", seen, 1);
        tick();
        chk("rstwait_busy_before", busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rstwait_busy", busy_o, 0);
        chk("rstwait_wptr", wptr_o, 0);
        chk("rstwait_ack", ack_o, 0);
        chk("rstwait_dma_start", dma_start, 0);
        chk("rstwait_addr", dma_addr, 0);
        chk("rstwait_data", dma_data, 0);
        dma_rd_en = 1'b1; req_i = 4'd0;
        tick();
        dma_rd_en = 1'b0;
        rst_n = 1'b1;
        model_idle_clear();
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rstwait_no_ack", ack_o, 0);
            chk("rstwait_no_irq", start_int_o, 0);
            chk("rstwait_idle", busy_o, 0);
        end
        do_word(4'b1010, 1, 1'b0, 8, 1'b0, oa, oi, oad);
        chk("rstwait_rr_restart", oa, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_chan_sched.md
DMA_CHAN_SCHED -- requirements
Module: dma_chan_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024; WAIT-state watchdog limit in clk cycles, used only with DMA_TIMEOUT_EN.
REQ-002 SHALL have port clk  in  1  TRN clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port enable_i  in  1  software run enable.
REQ-005 SHALL have port cfg_bus_mstr_enable  in  1  PCIe command bit 2; no new DMA issued while low.
REQ-006 SHALL have port req_i  in  4  per-channel word-ready request, level.
REQ-007 SHALL have port ch_data_i  in  128  channel data; channel n = bits [32n+31:32n].
REQ-008 SHALL have port buf_base_i  in  30  host buffer DW base address [31:2].
REQ-009 SHALL have port buf_size_i  in  16  host buffer length in DWs; 0 means 65536.
REQ-010 SHALL have port dma_rd_en  in  1  endpoint pulse: current DMA word consumed.
REQ-011 SHALL have port dma_start  out  1  one-cycle DMA request pulse to endpoint.
REQ-012 SHALL have port dma_addr  out  30  DMA DW address [31:2].
REQ-013 SHALL have port dma_data  out  32  DMA payload.
REQ-014 SHALL have port ack_o  out  4  one-cycle, one-hot grant-complete pulse per channel.
REQ-015 SHALL have port start_int_o  out  1  one-cycle MSI request pulse (to start_int_i).
REQ-016 SHALL have port busy_o  out  1  high in any state except IDLE.
REQ-017 SHALL have port wptr_o  out  16  current buffer write pointer in DWs.
REQ-018 SHALL have port err_o  out  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, START, WAIT.
REQ-020 IDLE: when enable_i=1, cfg_bus_mstr_enable=1 and req_i!=0, SHALL grant one channel round-robin, starting the search at last_grant+1 mod 4 (initial last_grant=3), and go to START.
REQ-021 START: SHALL assert dma_start for exactly one cycle, load dma_addr=buf_base_i+wptr (30-bit, modulo 2^30) and dma_data=granted channel word, then go to WAIT.
REQ-022 WAIT: SHALL hold dma_addr/dma_data stable until dma_rd_en=1; on dma_rd_en SHALL pulse ack_o[grant] one cycle later, advance wptr, go to IDLE.
REQ-023 dma_rd_en in IDLE or START SHALL be ignored.
REQ-024 Issue-to-issue spacing SHALL be at least 3 cycles (START, WAIT>=1, IDLE>=1).
REQ-025 wptr SHALL increment by 1 per completed word; at value (buf_size_i-1), or 65535 when size is 0, it SHALL wrap to 0 and start_int_o SHALL pulse one cycle coincident with the ack_o pulse.
REQ-026 enable_i deasserted during START/WAIT SHALL not abort; the word completes, then the FSM idles.
REQ-027 enable_i=0 while in IDLE SHALL clear wptr to 0 and last_grant to 3.
REQ-028 A req_i change on a non-granted channel during a transfer SHALL not affect the current grant.
REQ-029 buf_size_i changes SHALL take effect at the next wrap comparison; if wptr>=new size, the next completion SHALL wrap to 0 with interrupt.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, wptr=0, last_grant=3, and outputs dma_start=0, dma_addr=0, dma_data=0, ack_o=0, start_int_o=0, busy_o=0, err_o=0.
REQ-031 Reset mid-WAIT SHALL drop the transfer with no ack_o pulse and no interrupt.

Configuration
REQ-032 With DMA_TIMEOUT_EN defined, a counter SHALL run in WAIT; on reaching TIMEOUT_CYC without dma_rd_en, SHALL set err_o, return to IDLE, and pulse neither ack nor interrupt; wptr SHALL remain unchanged.
REQ-033 err_o SHALL clear only on reset or enable_i=0 in IDLE.
REQ-034 Without DMA_TIMEOUT_EN, WAIT SHALL hold indefinitely and err_o SHALL be tied to 0.

Verification
REQ-035 req_i=4'b1111 held, dma_rd_en 2 cycles after each dma_start -> grants 0,1,2,3,0 in order, with one ack pulse each.
REQ-036 buf_base_i=30'h100, buf_size_i=4, 5 words -> dma_addr sequence 100,101,102,103,100; start_int_o pulses once, with the 4th ack.
REQ-037 buf_size_i=0, 65536 words -> single interrupt at wptr 65535->0.
REQ-038 cfg_bus_mstr_enable=0 with req_i=4'b0001 -> no dma_start; raise to 1 -> dma_start within 2 cycles.
REQ-039 rst_n pulsed low during WAIT -> no ack_o pulse, wptr=0, busy_o=0 immediately.
REQ-040 DMA_TIMEOUT_EN, TIMEOUT_CYC=16, no dma_rd_en -> err_o=1 after 16 WAIT cycles, FSM back in IDLE, wptr unchanged.
